// File: rtl/slave_rd_sel_ctrl.sv
// rtl/slave_rd_sel_ctrl.sv - single-outstanding read select controller for the read switch
// Optional data-phase watchdog enabled by defining SLAVE_RD_WATCHDOG_EN.
module slave_rd_sel_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  sys_clk,
  input  logic                  sys_rstn,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic                  s_arvalid,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic                  m_rlast,
  input  logic                  s_rready,
  output logic                  s_araddr_en,
  output logic                  m_rvalid_sel_en,
  output logic [2:0]            rvalid_sel,
  output logic                  rd_busy,
  output logic                  ar_dec_err,
  output logic                  rlast_err,
  output logic                  rd_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] arlen_q, arlen_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       dec_err_q, dec_err_d;
  logic       rlast_err_q, rlast_err_d;
  logic       timeout_q, timeout_d;
  logic [1:0] region;
  logic       beat;
  logic       wd_expire;
  logic       unused_addr_bits;

  assign region           = s_araddr[ADDR_WIDTH-1:ADDR_WIDTH-2];
  assign beat             = m_rvalid && s_rready;
  assign unused_addr_bits = ^s_araddr[ADDR_WIDTH-3:0];

`ifdef SLAVE_RD_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;

  // Counts beat-less DATA cycles; expires on the TIMEOUT_CYCLES-th one.
  always_comb begin
    wd_d      = 16'd0;
    wd_expire = 1'b0;
    if (state_q == ST_DATA && !beat) begin
      wd_d      = wd_q + 16'd1;
      wd_expire = (wd_q == WD_LAST);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rstn) begin
      wd_q <= 16'd0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic [15:0] unused_timeout;

  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign wd_expire      = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rstn) begin
      state_q     <= ST_IDLE;
      sel_q       <= 3'b000;
      arlen_q     <= 8'd0;
      beat_cnt_q  <= 8'd0;
      dec_err_q   <= 1'b0;
      rlast_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      arlen_q     <= arlen_d;
      beat_cnt_q  <= beat_cnt_d;
      dec_err_q   <= dec_err_d;
      rlast_err_q <= rlast_err_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    arlen_d     = arlen_q;
    beat_cnt_d  = beat_cnt_q;
    dec_err_d   = 1'b0;
    rlast_err_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sel_d = 3'b000;
        if (s_arvalid) begin
          if (region == 2'b00) begin
            dec_err_d = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (!s_arvalid) begin
          state_d = ST_IDLE;
          sel_d   = 3'b000;
        end else if (m_arready) begin
          case (region)
            2'b01:   sel_d = 3'b001;
            2'b10:   sel_d = 3'b010;
            2'b11:   sel_d = 3'b100;
            default: sel_d = 3'b000;
          endcase
          arlen_d    = s_arlen;
          beat_cnt_d = 8'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (m_rlast) begin
            rlast_err_d = (beat_cnt_q != arlen_q);
            state_d     = ST_IDLE;
            sel_d       = 3'b000;
          end else begin
            // Length reached without rlast: flag it but keep draining until rlast.
            rlast_err_d = (beat_cnt_q == arlen_q);
          end
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          sel_d     = 3'b000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 3'b000;
      end
    endcase
  end

  always_comb begin
    s_araddr_en     = (state_q == ST_ADDR);
    m_rvalid_sel_en = (state_q == ST_DATA);
    rd_busy         = (state_q != ST_IDLE);
    rvalid_sel      = sel_q;
    ar_dec_err      = dec_err_q;
    rlast_err       = rlast_err_q;
    rd_timeout      = timeout_q;
  end

endmodule
